// File: rtl/memory_writeback_cycle_if.sv
// Data-memory port bundle for the memory/writeback stage.
//   dmem_req    access request (master -> memory)
//   dmem_we     1 = store
//   dmem_addr   word-aligned byte address
//   dmem_wdata  store data replicated into byte lanes
//   dmem_wstrb  byte enables
//   dmem_gnt    request accepted this cycle (memory -> master)
//   dmem_rvalid read data valid, loads only
//   dmem_rdata  read word
`timescale 1ns/1ps
interface memory_writeback_cycle_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_writeback_cycle.sv
// Memory + writeback stage of an RV32I pipeline.
// Issues loads/stores on a req/gnt/rvalid data port, aligns load data,
// selects the writeback value and registers RegWriteW/RDW/ResultW.
// stall_o holds the M-stage inputs while an access is outstanding.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   RegWriteM..PCPlus4M M-stage instruction fields (held while stall_o=1)
//   dmem                data-memory port (master side)
//   RegWriteW/RDW/ResultW  register-file write port
//   stall_o             freeze upstream stages
//   misalign_o          1-cycle pulse: misaligned access suppressed
//   bus_err_o           1-cycle pulse: gnt/rvalid timeout, access abandoned
`timescale 1ns/1ps
module memory_writeback_cycle #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic        LoadM,
  input  logic        StoreM,
  input  logic [4:0]  RD_M,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  memory_writeback_cycle_if.master dmem,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        regw_q, regw_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;

  logic        mem_op, misaligned, tmo_hit;
  logic        req_c, stall_c, mis_c, berr_c, done_c;
  logic [31:0] wb_val;

  function automatic logic [31:0] load_align(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    h  = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_align = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_align = {{16{h[15]}}, h};
      3'b100:  load_align = {24'd0, sh[7:0]};
      3'b101:  load_align = {16'd0, h};
      default: load_align = w;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b00:   store_wstrb = 4'b0001 << a;
      2'b01:   store_wstrb = 4'b0011 << a;
      default: store_wstrb = 4'hF;
    endcase
  endfunction

  assign mem_op     = LoadM | StoreM;
  assign misaligned = ((Funct3M[1:0] == 2'b01) && ALUResultM[0]) ||
                      ((Funct3M[1:0] == 2'b10) && (ALUResultM[1:0] != 2'b00));
  // cnt_q counts completed cycles in the current wait state, so this fires
  // on the TIMEOUT_CYC-th cycle spent waiting.
  assign tmo_hit    = (TIMEOUT_CYC != 0) && (cnt_q == TIMEOUT_CYC - 32'd1);

  always_comb begin
    case (ResultSrcM)
      2'b01:   wb_val = load_align(Funct3M, ALUResultM[1:0], dmem.dmem_rdata);
      2'b10:   wb_val = PCPlus4M;
      default: wb_val = ALUResultM;
    endcase
  end

  // Next-state / control
  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    berr_c  = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && misaligned) begin
          mis_c = 1'b1;
        end else if (mem_op) begin
          req_c   = 1'b1;
          stall_c = !(StoreM && dmem.dmem_gnt);
          if (!dmem.dmem_gnt)  state_d = REQ;
          else if (StoreM)     done_c  = 1'b1;
          else                 state_d = RESP;
        end else begin
          done_c = 1'b1;
        end
      end
      REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        // gnt wins over a coincident rvalid: read data must follow the grant.
        if (dmem.dmem_gnt) begin
          if (StoreM) begin
            done_c  = 1'b1;
            stall_c = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = RESP;
          end
        end else if (tmo_hit) begin
          berr_c  = 1'b1;
          stall_c = 1'b0;
          state_d = IDLE;
        end
      end
      RESP: begin
        stall_c = 1'b1;
        if (dmem.dmem_rvalid) begin
          done_c  = 1'b1;
          stall_c = 1'b0;
          state_d = IDLE;
        end else if (tmo_hit) begin
          berr_c  = 1'b1;
          stall_c = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? 32'd0 : cnt_q + 32'd1;
    regw_d = done_c && RegWriteM && (RD_M != 5'd0);
    rd_d   = done_c ? RD_M   : rd_q;
    res_d  = done_c ? wb_val : res_q;
  end

  // Combinational outputs are masked while reset is held so every output reads 0.
  assign dmem.dmem_req   = req_c & ~rst;
  assign dmem.dmem_we    = dmem.dmem_req & StoreM;
  assign dmem.dmem_addr  = dmem.dmem_req ? {ALUResultM[31:2], 2'b00} : 32'd0;
  assign dmem.dmem_wdata = (dmem.dmem_req && StoreM) ? store_wdata(Funct3M, WriteDataM) : 32'd0;
  assign dmem.dmem_wstrb = (dmem.dmem_req && StoreM) ? store_wstrb(Funct3M, ALUResultM[1:0]) : 4'd0;
  assign stall_o         = stall_c & ~rst;
  assign misalign_o      = mis_c & ~rst;
  assign bus_err_o       = berr_c & ~rst;

  // M -> W register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      regw_q  <= 1'b0;
      rd_q    <= 5'd0;
      res_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regw_q  <= regw_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
    end
  end

  assign RegWriteW = regw_q;
  assign RDW       = rd_q;
  assign ResultW   = res_q;

endmodule
